// File: rtl/exe_stage_pkg.sv
// Shared pipeline constants for the execute stage: ALU command codes,
// shift-type codes, forwarding-select codes, the status-flag layout and
// small arithmetic helpers used by the ALU and the Val2 generator.
package exe_stage_pkg;

    localparam int DATA_W = 32;

    // ALU command encodings carried on exe_cmd
    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    // Register-operand shift types carried in shift_operand[6:5]
    typedef enum logic [1:0] {
        SHIFT_LSL = 2'b00,
        SHIFT_LSR = 2'b01,
        SHIFT_ASR = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_e;

    // Operand forwarding selects; 11 behaves like 00
    typedef enum logic [1:0] {
        FWD_IDEX     = 2'b00,
        FWD_EXMEM    = 2'b01,
        FWD_WB       = 2'b10,
        FWD_IDEX_ALT = 2'b11
    } fwd_sel_e;

    // Status flags, packed so that {n,z,c,v} maps directly onto status_out
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    // Rotate right; an amount of 0 returns the value untouched because the
    // left shift by 32 contributes nothing.
    function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] x,
                                                 input logic [4:0]        amt);
        logic [5:0] back;
        back = 6'd32 - {1'b0, amt};
        return (x >> amt) | (x << back);
    endfunction

    // Signed overflow of a + b given the 32-bit result sign
    function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a - b given the 32-bit result sign
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator: rotated 8-bit immediate, 12-bit memory offset,
// or the shifted register operand.
module val2_gen
    import exe_stage_pkg::*;
(
    input  logic [31:0] rm,
    input  logic [11:0] shift_operand,
    input  logic        imm,
    input  logic        mem_en,
    output logic [31:0] val2
);

    logic [4:0] shift_amt;
    logic [4:0] rot_amt;

    assign shift_amt = shift_operand[11:7];
    assign rot_amt   = {shift_operand[11:8], 1'b0};

    // Pick the operand form; a zero shift amount passes Rm through as-is
    always_comb begin
        val2 = rm;
        if (imm) begin
            val2 = ror32({24'd0, shift_operand[7:0]}, rot_amt);
        end else if (mem_en) begin
            val2 = {20'd0, shift_operand};
        end else if (shift_amt != 5'd0) begin
            case (shift_e'(shift_operand[6:5]))
                SHIFT_LSL: val2 = rm << shift_amt;
                SHIFT_LSR: val2 = rm >> shift_amt;
                SHIFT_ASR: val2 = $signed(rm) >>> shift_amt;
                SHIFT_ROR: val2 = ror32(rm, shift_amt);
                default:   val2 = rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, Val2 generation, ALU, status register,
// branch target calculation and the EX/MEM pipeline register.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  dest_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic        imm_in,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic [1:0]  fwd_sel1,
    input  logic [1:0]  fwd_sel2,
    input  logic [31:0] wb_value_in,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [3:0]  status_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] st_val_out,
    output logic [3:0]  dest_out,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic        mem_w_en_out
);

    logic [31:0] op_a;
    logic [31:0] op_rm;
    logic [31:0] val2;
    logic [31:0] alu_res;
    logic [32:0] arith;
    logic        cmd_valid;
    flags_t      status_q;
    flags_t      status_nxt;

    // Operand A forwarding; the EX/MEM path uses the value before this edge
    always_comb begin
        case (fwd_sel_e'(fwd_sel1))
            FWD_EXMEM: op_a = alu_res_out;
            FWD_WB:    op_a = wb_value_in;
            default:   op_a = val_rn_in;
        endcase
    end

    // Rm forwarding, shared by the shifter and the store-data path
    always_comb begin
        case (fwd_sel_e'(fwd_sel2))
            FWD_EXMEM: op_rm = alu_res_out;
            FWD_WB:    op_rm = wb_value_in;
            default:   op_rm = val_rm_in;
        endcase
    end

    val2_gen u_val2_gen (
        .rm            (op_rm),
        .shift_operand (shift_operand_in),
        .imm           (imm_in),
        .mem_en        (mem_r_en_in | mem_w_en_in),
        .val2          (val2)
    );

    // ALU: 33-bit arithmetic for carry/borrow; unknown commands give 0 and keep flags
    always_comb begin
        alu_res    = '0;
        arith      = '0;
        cmd_valid  = 1'b1;
        status_nxt = status_q;
        case (exe_cmd_e'(exe_cmd_in))
            EXE_MOV: alu_res = val2;
            EXE_MVN: alu_res = ~val2;
            EXE_AND: alu_res = op_a & val2;
            EXE_ORR: alu_res = op_a | val2;
            EXE_EOR: alu_res = op_a ^ val2;
            EXE_ADD: begin
                arith        = {1'b0, op_a} + {1'b0, val2};
                alu_res      = arith[31:0];
                status_nxt.c = arith[32];
                status_nxt.v = add_ovf(op_a[31], val2[31], arith[31]);
            end
            EXE_ADC: begin
                arith        = {1'b0, op_a} + {1'b0, val2} + {32'd0, status_q.c};
                alu_res      = arith[31:0];
                status_nxt.c = arith[32];
                status_nxt.v = add_ovf(op_a[31], val2[31], arith[31]);
            end
            EXE_SUB: begin
                arith        = {1'b0, op_a} - {1'b0, val2};
                alu_res      = arith[31:0];
                status_nxt.c = ~arith[32];
                status_nxt.v = sub_ovf(op_a[31], val2[31], arith[31]);
            end
            EXE_SBC: begin
                arith        = {1'b0, op_a} - {1'b0, val2} - {32'd0, ~status_q.c};
                alu_res      = arith[31:0];
                status_nxt.c = ~arith[32];
                status_nxt.v = sub_ovf(op_a[31], val2[31], arith[31]);
            end
            default: cmd_valid = 1'b0;
        endcase
        if (cmd_valid) begin
            status_nxt.n = alu_res[31];
            status_nxt.z = (alu_res == 32'd0);
        end
    end

    // Status register: loads on S-suffixed instructions unless stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
        end else if (!freeze && s_in) begin
            status_q <= status_nxt;
        end
    end

    // EX/MEM register: reset wins over freeze and drops any in-flight result
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_res_out  <= '0;
            st_val_out   <= '0;
            dest_out     <= '0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            mem_w_en_out <= 1'b0;
        end else if (!freeze) begin
            alu_res_out  <= alu_res;
            st_val_out   <= op_rm;
            dest_out     <= dest_in;
            wb_en_out    <= wb_en_in;
            mem_r_en_out <= mem_r_en_in;
            mem_w_en_out <= mem_w_en_in;
        end
    end

    assign status_out   = status_q;
    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

endmodule

// File: tb/tb_exe_stage.sv
// Directed testbench for exe_stage with hand-computed expected values.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic [31:0] pc_in;
    logic [31:0] val_rn_in;
    logic [31:0] val_rm_in;
    logic [3:0]  dest_in;
    logic [3:0]  exe_cmd_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic        imm_in;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic        b_in;
    logic        s_in;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;
    logic [31:0] wb_value_in;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [3:0]  status_out;
    logic [31:0] alu_res_out;
    logic [31:0] st_val_out;
    logic [3:0]  dest_out;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic        mem_w_en_out;

    int vectors     = 0;
    int miscompares = 0;

    exe_stage dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .pc_in            (pc_in),
        .val_rn_in        (val_rn_in),
        .val_rm_in        (val_rm_in),
        .dest_in          (dest_in),
        .exe_cmd_in       (exe_cmd_in),
        .shift_operand_in (shift_operand_in),
        .signed_imm_24_in (signed_imm_24_in),
        .imm_in           (imm_in),
        .wb_en_in         (wb_en_in),
        .mem_r_en_in      (mem_r_en_in),
        .mem_w_en_in      (mem_w_en_in),
        .b_in             (b_in),
        .s_in             (s_in),
        .fwd_sel1         (fwd_sel1),
        .fwd_sel2         (fwd_sel2),
        .wb_value_in      (wb_value_in),
        .branch_taken     (branch_taken),
        .branch_addr      (branch_addr),
        .status_out       (status_out),
        .alu_res_out      (alu_res_out),
        .st_val_out       (st_val_out),
        .dest_out         (dest_out),
        .wb_en_out        (wb_en_out),
        .mem_r_en_out     (mem_r_en_out),
        .mem_w_en_out     (mem_w_en_out)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Zero every ID/EX-side input (a flushed bubble)
    task automatic clearInputs();
        freeze           = 1'b0;
        pc_in            = '0;
        val_rn_in        = '0;
        val_rm_in        = '0;
        dest_in          = '0;
        exe_cmd_in       = '0;
        shift_operand_in = '0;
        signed_imm_24_in = '0;
        imm_in           = 1'b0;
        wb_en_in         = 1'b0;
        mem_r_en_in      = 1'b0;
        mem_w_en_in      = 1'b0;
        b_in             = 1'b0;
        s_in             = 1'b0;
        fwd_sel1         = 2'b00;
        fwd_sel2         = 2'b00;
        wb_value_in      = '0;
    endtask

    // Present one ALU instruction; other fields keep their current values
    task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] rn,
                                 input logic [31:0] rm, input logic [11:0] so,
                                 input logic im, input logic s);
        exe_cmd_in       = cmd;
        val_rn_in        = rn;
        val_rm_in        = rm;
        shift_operand_in = so;
        imm_in           = im;
        s_in             = s;
    endtask

    // Advance one clock and sample 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        clearInputs();
        rst = 1'b1;

        // Reset with a live instruction on the inputs
        applyStimulus(4'b0010, 32'd9, 32'd0, 12'h001, 1'b1, 1'b1);
        wb_en_in = 1'b1; dest_in = 4'd5; mem_w_en_in = 1'b1;
        tick();
        checkOutput("rst_alu",   alu_res_out, 32'h0);
        checkOutput("rst_st",    st_val_out, 32'h0);
        checkOutput("rst_dest",  {28'd0, dest_out}, 32'h0);
        checkOutput("rst_wb",    {31'd0, wb_en_out}, 32'h0);
        checkOutput("rst_memr",  {31'd0, mem_r_en_out}, 32'h0);
        checkOutput("rst_memw",  {31'd0, mem_w_en_out}, 32'h0);
        checkOutput("rst_status",{28'd0, status_out}, 32'h0);
        rst = 1'b0;
        mem_w_en_in = 1'b0;

        // ADDS 0x7FFFFFFF + 1 -> signed overflow
        applyStimulus(4'b0010, 32'h7FFF_FFFF, 32'd0, 12'h001, 1'b1, 1'b1);
        dest_in = 4'd3;
        tick();
        checkOutput("adds_ovf_res", alu_res_out, 32'h8000_0000);
        checkOutput("adds_ovf_nzcv", {28'd0, status_out}, 32'h9);
        checkOutput("adds_dest", {28'd0, dest_out}, 32'h3);
        checkOutput("adds_wb", {31'd0, wb_en_out}, 32'h1);

        // SUBS 5 - 5 -> zero, no borrow
        applyStimulus(4'b0100, 32'd5, 32'd0, 12'h005, 1'b1, 1'b1);
        tick();
        checkOutput("subs_res", alu_res_out, 32'h0);
        checkOutput("subs_nzcv", {28'd0, status_out}, 32'h6);

        // ADC 1 + 1 + C(1)
        applyStimulus(4'b0011, 32'd1, 32'd0, 12'h001, 1'b1, 1'b0);
        tick();
        checkOutput("adc_res", alu_res_out, 32'h3);
        checkOutput("adc_keep_flags", {28'd0, status_out}, 32'h6);

        // MOVS rotated immediate 0x4FF -> 0xFF000000, C/V kept
        applyStimulus(4'b0001, 32'd0, 32'd0, 12'h4FF, 1'b1, 1'b1);
        tick();
        checkOutput("mov_rotimm", alu_res_out, 32'hFF00_0000);
        checkOutput("movs_nzcv", {28'd0, status_out}, 32'hA);

        // Register shifts on Rm through MOV
        applyStimulus(4'b0001, 32'd0, 32'h8000_0000, 12'h240, 1'b0, 1'b0);
        tick();
        checkOutput("asr4", alu_res_out, 32'hF800_0000);
        applyStimulus(4'b0001, 32'd0, 32'h0000_00F1, 12'h260, 1'b0, 1'b0);
        tick();
        checkOutput("ror4", alu_res_out, 32'h1000_000F);
        applyStimulus(4'b0001, 32'd0, 32'h0000_0001, 12'hF80, 1'b0, 1'b0);
        tick();
        checkOutput("lsl31", alu_res_out, 32'h8000_0000);
        applyStimulus(4'b0001, 32'd0, 32'h8000_0000, 12'hFA0, 1'b0, 1'b0);
        tick();
        checkOutput("lsr31", alu_res_out, 32'h0000_0001);
        applyStimulus(4'b0001, 32'd0, 32'h1234_5678, 12'h040, 1'b0, 1'b0);
        tick();
        checkOutput("asr0_pass", alu_res_out, 32'h1234_5678);

        // Branch target, combinational
        pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFE; b_in = 1'b1;
        #1;
        checkOutput("branch_addr", branch_addr, 32'h0000_00F8);
        checkOutput("branch_taken", {31'd0, branch_taken}, 32'h1);
        signed_imm_24_in = 24'h000010;
        #1;
        checkOutput("branch_fwd", branch_addr, 32'h0000_0140);
        b_in = 1'b0;

        // Forwarding: ADD -> 7, then dependent ADD via EX/MEM path -> 8
        applyStimulus(4'b0010, 32'd6, 32'd0, 12'h001, 1'b1, 1'b0);
        tick();
        checkOutput("fwd_base", alu_res_out, 32'h7);
        applyStimulus(4'b0010, 32'h55, 32'd0, 12'h001, 1'b1, 1'b0);
        fwd_sel1 = 2'b01;
        tick();
        checkOutput("fwd_exmem", alu_res_out, 32'h8);
        fwd_sel1 = 2'b00;

        // STR with store data forwarded from write-back
        applyStimulus(4'b0010, 32'h1000, 32'hDEAD, 12'h004, 1'b0, 1'b0);
        mem_w_en_in = 1'b1; wb_en_in = 1'b0; fwd_sel2 = 2'b10; wb_value_in = 32'h20;
        tick();
        checkOutput("str_addr", alu_res_out, 32'h1004);
        checkOutput("str_val", st_val_out, 32'h20);
        checkOutput("str_memw", {31'd0, mem_w_en_out}, 32'h1);
        checkOutput("str_wb", {31'd0, wb_en_out}, 32'h0);
        mem_w_en_in = 1'b0; fwd_sel2 = 2'b00;

        // LDR with a 12-bit offset
        applyStimulus(4'b0010, 32'h100, 32'd0, 12'hFFF, 1'b0, 1'b0);
        mem_r_en_in = 1'b1; wb_en_in = 1'b1;
        tick();
        checkOutput("ldr_addr", alu_res_out, 32'h10FF);
        checkOutput("ldr_memr", {31'd0, mem_r_en_out}, 32'h1);
        mem_r_en_in = 1'b0;

        // SUBS 3 - 5 -> borrow clears C; SBC 5 - 3 - 1
        applyStimulus(4'b0100, 32'd3, 32'd0, 12'h005, 1'b1, 1'b1);
        tick();
        checkOutput("subs_neg", alu_res_out, 32'hFFFF_FFFE);
        checkOutput("subs_neg_nzcv", {28'd0, status_out}, 32'h8);
        applyStimulus(4'b0101, 32'd5, 32'd0, 12'h003, 1'b1, 1'b0);
        tick();
        checkOutput("sbc_res", alu_res_out, 32'h1);

        // Freeze for two cycles during ADDS 0xFFFFFFFF + 1
        applyStimulus(4'b0010, 32'hFFFF_FFFF, 32'd0, 12'h001, 1'b1, 1'b1);
        freeze = 1'b1;
        tick();
        checkOutput("frz1_res", alu_res_out, 32'h1);
        checkOutput("frz1_nzcv", {28'd0, status_out}, 32'h8);
        tick();
        checkOutput("frz2_res", alu_res_out, 32'h1);
        checkOutput("frz2_nzcv", {28'd0, status_out}, 32'h8);
        freeze = 1'b0;
        tick();
        checkOutput("unfrz_res", alu_res_out, 32'h0);
        checkOutput("unfrz_nzcv", {28'd0, status_out}, 32'h6);

        // Logical ops keep C and V
        applyStimulus(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 12'h000, 1'b0, 1'b1);
        tick();
        checkOutput("ands_res", alu_res_out, 32'hF000_F000);
        checkOutput("ands_nzcv", {28'd0, status_out}, 32'hA);
        applyStimulus(4'b0111, 32'hF0, 32'd0, 12'h00F, 1'b1, 1'b0);
        tick();
        checkOutput("orr_res", alu_res_out, 32'hFF);
        applyStimulus(4'b1000, 32'hFF, 32'd0, 12'h00F, 1'b1, 1'b0);
        tick();
        checkOutput("eor_res", alu_res_out, 32'hF0);
        applyStimulus(4'b1001, 32'd0, 32'd0, 12'h000, 1'b1, 1'b0);
        tick();
        checkOutput("mvn_res", alu_res_out, 32'hFFFF_FFFF);

        // Undefined command with S set: result 0, flags untouched
        applyStimulus(4'b1111, 32'd7, 32'd0, 12'h001, 1'b1, 1'b1);
        dest_in = 4'd9; wb_en_in = 1'b1;
        tick();
        checkOutput("undef_res", alu_res_out, 32'h0);
        checkOutput("undef_nzcv", {28'd0, status_out}, 32'hA);
        checkOutput("undef_wb", {31'd0, wb_en_out}, 32'h1);

        // Flushed entry becomes a bubble
        clearInputs();
        tick();
        checkOutput("bubble_wb", {31'd0, wb_en_out}, 32'h0);
        checkOutput("bubble_dest", {28'd0, dest_out}, 32'h0);
        checkOutput("bubble_nzcv", {28'd0, status_out}, 32'hA);

        // Make outputs non-zero, then reset together with freeze
        applyStimulus(4'b0010, 32'd1, 32'h77, 12'h001, 1'b1, 1'b0);
        wb_en_in = 1'b1; dest_in = 4'd4;
        tick();
        checkOutput("pre_rst_res", alu_res_out, 32'h2);
        freeze = 1'b1; rst = 1'b1;
        tick();
        checkOutput("rstfrz_res", alu_res_out, 32'h0);
        checkOutput("rstfrz_st", st_val_out, 32'h0);
        checkOutput("rstfrz_wb", {31'd0, wb_en_out}, 32'h0);
        checkOutput("rstfrz_nzcv", {28'd0, status_out}, 32'h0);
        rst = 1'b0; freeze = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, rst; all state SHALL change only on the rising edge of clk.
REQ-002 Port clk, input, 1, rising-edge clock.
REQ-003 Port rst, input, 1, synchronous active-high reset.
REQ-004 Port freeze, input, 1, high holds all registered state (EX/MEM outputs and status register) for the cycle.
REQ-005 Inputs from the ID/EX register SHALL be: pc_in 32 (PC+4); val_rn_in 32; val_rm_in 32; dest_in 4; exe_cmd_in 4; shift_operand_in 12; signed_imm_24_in 24; imm_in 1; wb_en_in 1; mem_r_en_in 1; mem_w_en_in 1; b_in 1; s_in 1.
REQ-006 Forwarding inputs SHALL be: fwd_sel1 2 and fwd_sel2 2 (00 = ID/EX value, 01 = own alu_res_out, 10 = wb_value_in, 11 = ID/EX value); wb_value_in 32.
REQ-007 Combinational outputs SHALL be: branch_taken 1 (= b_in); branch_addr 32; status_out 4 ({N,Z,C,V}, current register value, feeds the ID-stage carry input).
REQ-008 Registered EX/MEM outputs SHALL be: alu_res_out 32; st_val_out 32 (forwarded Rm); dest_out 4; wb_en_out 1; mem_r_en_out 1; mem_w_en_out 1.

Function
REQ-009 Operand A SHALL be val_rn_in, alu_res_out or wb_value_in per fwd_sel1; Rm SHALL be selected likewise per fwd_sel2.
REQ-010 Val2 SHALL be: when imm_in=1, shift_operand[7:0] zero-extended and rotated right by 2*shift_operand[11:8].
REQ-011 Otherwise, when mem_r_en_in or mem_w_en_in is set, Val2 SHALL be shift_operand[11:0] zero-extended.
REQ-012 Otherwise, Val2 SHALL be Rm shifted by shift_operand[11:7] with type shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR); a shift amount of 0 SHALL pass Rm unchanged.
REQ-013 ALU commands on exe_cmd_in SHALL be: 0001 MOV Val2; 1001 MVN ~Val2; 0010 ADD A+Val2; 0011 ADC A+Val2+C; 0100 SUB A-Val2; 0101 SBC A-Val2-~C; 0110 AND; 0111 ORR; 1000 EOR; any other code SHALL produce result 0 with flags unchanged.
REQ-014 Arithmetic SHALL be computed 33 bits wide; C SHALL be bit 32 for ADD/ADC and NOT borrow for SUB/SBC; V SHALL be the signed overflow of the 32-bit result.
REQ-015 N and Z SHALL come from result[31] and (result==0); logical and move commands SHALL leave C and V unchanged.
REQ-016 The status register SHALL load the new flags on a clock edge when s_in=1 and freeze=0, and hold otherwise.
REQ-017 branch_addr SHALL be pc_in + (sign_extend(signed_imm_24_in) << 2), computed modulo 2^32.
REQ-018 When freeze=0, EX/MEM outputs SHALL capture the ALU result, the forwarded Rm and the control inputs one cycle after presentation (latency 1).
REQ-019 fwd_sel=01 SHALL use the pre-edge alu_res_out, so back-to-back dependent instructions see the previous result.
REQ-020 A flushed (all-zero) ID/EX entry SHALL propagate as a bubble: wb_en_out, mem_r_en_out and mem_w_en_out SHALL be 0, and status SHALL not change because s_in=0.
REQ-021 When rst and freeze are high together, rst SHALL win.

Reset
REQ-022 On a clock edge with rst=1, alu_res_out, st_val_out, dest_out, wb_en_out, mem_r_en_out, mem_w_en_out and the status register SHALL all become 0; reset asserted mid-operation SHALL discard the in-flight result.
REQ-023 Combinational outputs SHALL follow their inputs during reset; status_out SHALL read 0 from the first edge with rst=1.

Structure
REQ-024 The exe_cmd codes, shift-type codes and fwd_sel codes SHALL be constants in the shared pipeline package.
REQ-025 Val2 generation SHALL be a sub-module named val2_gen; the ALU, status register and EX/MEM register SHALL remain in exe_stage.

Verification
REQ-026 Scenario: ADD with s_in=1, A=0x7FFFFFFF, Val2=1 -> next cycle alu_res_out=0x80000000 and status=N1 Z0 C0 V1.
REQ-027 Scenario: SUB with s_in=1, A=5, Val2=5 -> result 0 and status=N0 Z1 C1 V0; a following ADC 1+1 -> result 3.
REQ-028 Scenario: imm_in=1 with shift_operand=0x4FF -> Val2=0xFF000000; with imm_in=0, ASR #4 on Rm=0x80000000 -> Val2=0xF8000000.
REQ-029 Scenario: pc_in=0x100, signed_imm_24=0xFFFFFE -> branch_addr=0xF8; b_in=1 -> branch_taken=1.
REQ-030 Scenario: ADD writes 7, then a dependent ADD with fwd_sel1=01 and Val2=1 -> 8; wb_value_in=0x20 with fwd_sel2=10 on a STR -> st_val_out=0x20.
REQ-031 Scenario: freeze=1 for 2 cycles during an ADDS -> outputs and flags held, then update after release; rst pulsed with freeze=1 -> all outputs 0.
